camera_receiver: RTL and testbench

//  Consumer end of the camera word handshake: requests bus words from the camera source,

---
 rtl/camera_receiver.sv | 213 +++++++++++++++++++++
 tb/tb_camera_receiver.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_receiver.sv
// camera_receiver: consumer end of the camera word handshake.
// Requests a bus word from the camera, captures it, then streams it out as
// PIX_WIDTH-bit pixels (MSB slice first) on a valid/ready interface, tagging
// each pixel with x/y coordinates and sof/eol/eof markers.
//
// Handshakes:
//   Camera side: recieve_ready is held high while waiting for the camera to
//   accept (in_progress=1). The word is then captured on the first cycle with
//   data_valid=1 and in_progress=0.
//   Pixel side: a pixel transfers on any cycle with pix_valid & pix_ready.
//   While pix_valid is high and pix_ready is low, pix_data, pix_x, pix_y and
//   the markers are held stable. pix_valid never drops without a transfer,
//   except on reset.
module camera_receiver #(
  parameter int BUS_WIDTH = 96,
  parameter int PIX_WIDTH = 24,
  parameter int SHAPE_W   = 848,
  parameter int SHAPE_H   = 480,
  parameter int TIMEOUT   = 1024,
  localparam int XW = (SHAPE_W > 1) ? $clog2(SHAPE_W) : 1,
  localparam int YW = (SHAPE_H > 1) ? $clog2(SHAPE_H) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 recieve_ready,
  input  logic                 in_progress,
  input  logic [BUS_WIDTH-1:0] data,
  input  logic                 data_valid,
  input  logic                 frame_end,
  output logic [PIX_WIDTH-1:0] pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [XW-1:0]        pix_x,
  output logic [YW-1:0]        pix_y,
  output logic                 pix_sof,
  output logic                 pix_eol,
  output logic                 pix_eof,
  output logic [15:0]          frame_count,
  output logic                 frame_err,
  output logic                 timeout_err,
  output logic [1:0]           dbg_state
);

  localparam int PPW   = BUS_WIDTH / PIX_WIDTH;
  localparam int WORDS = SHAPE_W * SHAPE_H / PPW;
  localparam int SW    = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_UNPACK = 2'd3;

  logic [1:0]           state_q,   state_d;
  logic                 rr_q,      rr_d;
  logic [BUS_WIDTH-1:0] word_q,    word_d;
  logic [SW-1:0]        slice_q,   slice_d;
  logic                 last_q,    last_d;     // word carried a frame_end rise
  logic [XW-1:0]        x_q,       x_d;
  logic [YW-1:0]        y_q,       y_d;
  logic [WW-1:0]        wcnt_q,    wcnt_d;     // index of the word within the frame
  logic [TW-1:0]        tmo_q,     tmo_d;
  logic                 tmo_err_q, tmo_err_d;
  logic [15:0]          fc_q,      fc_d;
  logic                 ferr_q,    ferr_d;
  logic                 fe_q;

  logic                 capture;
  logic                 fe_rise;
  logic                 last_slice;
  logic                 at_frame_end;
  logic                 eof_c;
  logic [PIX_WIDTH-1:0] pix_c;

  assign capture      = (state_q == S_WAIT) && data_valid && !in_progress;
  assign fe_rise      = frame_end && !fe_q;
  assign last_slice   = (slice_q == SW'(PPW - 1));
  assign at_frame_end = (x_q == XW'(SHAPE_W - 1)) && (y_q == YW'(SHAPE_H - 1));
  // A frame ends either at the last coordinate or at the last pixel of a word
  // that arrived with a frame_end rise (early end).
  assign eof_c        = at_frame_end || (last_q && last_slice);

  // Select the current pixel slice, MSB slice first.
  always_comb begin
    pix_c = '0;
    for (int i = 0; i < PPW; i++) begin
      if (slice_q == SW'(i)) begin
        pix_c = word_q[BUS_WIDTH-1-i*PIX_WIDTH -: PIX_WIDTH];
      end
    end
  end

  // Next-state logic: request/wait/capture, timeout, and pixel unpacking.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    slice_d   = slice_q;
    last_d    = last_q;
    x_d       = x_q;
    y_d       = y_q;
    wcnt_d    = wcnt_q;
    tmo_d     = tmo_q;
    tmo_err_d = 1'b0;
    fc_d      = fc_q;
    ferr_d    = ferr_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_REQ;
        end
      end

      S_REQ, S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (capture) begin
          // Capture wins over a coincident timeout: the word is already here.
          word_d  = data;
          last_d  = fe_rise;
          slice_d = '0;
          tmo_d   = '0;
          state_d = S_UNPACK;
          if (fe_rise && (wcnt_q != WW'(WORDS - 1))) begin
            ferr_d = 1'b1;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          tmo_err_d = 1'b1;
          tmo_d     = '0;
          state_d   = S_REQ;
        end else if ((state_q == S_REQ) && in_progress) begin
          state_d = S_WAIT;
        end
      end

      S_UNPACK: begin
        if (pix_ready) begin
          if (eof_c) begin
            x_d  = '0;
            y_d  = '0;
            fc_d = fc_q + 16'd1;
          end else if (x_q == XW'(SHAPE_W - 1)) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end

          if (last_slice) begin
            slice_d = '0;
            last_d  = 1'b0;
            wcnt_d  = eof_c ? '0 : wcnt_q + WW'(1);
            state_d = enable ? S_REQ : S_IDLE;
          end else begin
            slice_d = slice_q + SW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    rr_d = (state_d == S_REQ);
  end

  // State registers with synchronous reset; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      word_q    <= '0;
      slice_q   <= '0;
      last_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      wcnt_q    <= '0;
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
      fc_q      <= '0;
      ferr_q    <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      word_q    <= word_d;
      slice_q   <= slice_d;
      last_q    <= last_d;
      x_q       <= x_d;
      y_q       <= y_d;
      wcnt_q    <= wcnt_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
      fc_q      <= fc_d;
      ferr_q    <= ferr_d;
      fe_q      <= frame_end;
    end
  end

  assign recieve_ready = rr_q;
  assign pix_valid     = (state_q == S_UNPACK);
  assign pix_data      = pix_c;
  assign pix_x         = x_q;
  assign pix_y         = y_q;
  assign pix_sof       = pix_valid && (x_q == '0) && (y_q == '0);
  assign pix_eol       = pix_valid && (x_q == XW'(SHAPE_W - 1));
  assign pix_eof       = pix_valid && eof_c;
  assign frame_count   = fc_q;
  assign frame_err     = ferr_q;
  assign timeout_err   = tmo_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_camera_receiver.sv
// Bench for camera_receiver on a small 8x2 frame with a 16-cycle timeout.
// A reference model turns each delivered word into the expected pixel
// records using frame pixel-index arithmetic; a monitor pops and compares
// every transferred pixel.
module tb_camera_receiver;

  localparam int BW    = 96;
  localparam int PW    = 24;
  localparam int SW_   = 8;
  localparam int SH    = 2;
  localparam int TMO   = 16;
  localparam int PPW   = BW / PW;
  localparam int NPIX  = SW_ * SH;
  localparam int WORDS = NPIX / PPW;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          recieve_ready;
  logic          in_progress = 1'b0;
  logic [BW-1:0] data = '0;
  logic          data_valid = 1'b0;
  logic          frame_end = 1'b0;
  logic [PW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [2:0]    pix_x;
  logic [0:0]    pix_y;
  logic          pix_sof, pix_eol, pix_eof;
  logic [15:0]   frame_count;
  logic          frame_err;
  logic          timeout_err;
  logic [1:0]    dbg_state;

  camera_receiver #(
    .BUS_WIDTH(BW), .PIX_WIDTH(PW), .SHAPE_W(SW_), .SHAPE_H(SH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .recieve_ready(recieve_ready),
    .in_progress(in_progress), .data(data), .data_valid(data_valid),
    .frame_end(frame_end), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .frame_count(frame_count),
    .frame_err(frame_err), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q[$];
  int          m_pidx;
  int          m_fc;
  logic        m_ferr;
  logic        m_prev_fe;

  function automatic logic [31:0] pack_rec(input logic [23:0] p, input logic [2:0] x,
                                           input logic y, input logic s, input logic e,
                                           input logic f);
    return {1'b0, p, x, y, s, e, f};
  endfunction

  task automatic model_reset();
    m_pidx    = 0;
    m_fc      = 0;
    m_ferr    = 1'b0;
    m_prev_fe = 1'b0;
    exp_q.delete();
  endtask

  // One captured word becomes PPW pixels at consecutive frame positions.
  task automatic model_word(input logic [BW-1:0] d, input logic lvl);
    logic          rise;
    logic [BW-1:0] sh;
    logic          eof;
    rise      = lvl && !m_prev_fe;
    m_prev_fe = lvl;
    if (rise && (m_pidx / PPW) != WORDS - 1) m_ferr = 1'b1;
    for (int i = 0; i < PPW; i++) begin
      sh  = d >> ((PPW - 1 - i) * PW);
      eof = (m_pidx == NPIX - 1) || (rise && i == PPW - 1);
      exp_q.push_back(pack_rec(sh[23:0], 3'(m_pidx % SW_), 1'(m_pidx / SW_),
                               m_pidx == 0, (m_pidx % SW_) == SW_ - 1, eof));
      if (eof) begin
        m_pidx = 0;
        m_fc   = (m_fc + 1) & 16'hFFFF;
      end else begin
        m_pidx++;
      end
    end
  endtask

  // ---------------- downstream ready generator ----------------
  logic rdy_rand = 1'b0;
  logic rdy_hold = 1'b1;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      pix_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_hold;
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] held_rec;
  logic        held_v = 1'b0;
  initial begin
    logic [31:0] got;
    forever begin
      @(negedge clk);
      got = pack_rec(pix_data, pix_x, pix_y[0], pix_sof, pix_eol, pix_eof);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) check_val("stall_hold", {pix_valid, got}, {1'b1, held_rec});
        if (pix_valid) begin
          check_val("no_req_in_unpack", recieve_ready, 1'b0);
          if (pix_ready) begin
            check_val("pixel", got, (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_0000_0000);
            held_v = 1'b0;
          end else begin
            held_v   = 1'b1;
            held_rec = got;
          end
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst         = 1'b1;
    enable      = 1'b0;
    in_progress = 1'b0;
    data_valid  = 1'b0;
    frame_end   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Camera side of one word: accept the request, then present the word.
  task automatic send_word(input logic [BW-1:0] d, input logic lvl, input logic drop_en);
    int n;
    n = 0;
    while (recieve_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_val("req_seen", recieve_ready, 1'b1);
    repeat ($urandom_range(0, 2)) tick();
    in_progress = 1'b1;
    tick();
    in_progress = 1'b0;
    if (drop_en) enable = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    data       = d;
    data_valid = 1'b1;
    frame_end  = lvl;
    tick();
    data_valid = 1'b0;
    model_word(d, lvl);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check_val("drain", exp_q.size(), 0);
  endtask

  function automatic logic [BW-1:0] rand_word();
    return {$urandom, $urandom, $urandom};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int   n;
    logic seen;
    logic lvl;

    rdy_rand = 1'b0;
    rdy_hold = 1'b1;
    do_reset();

    // Reset state, and no request while disabled.
    check_val("rst_recieve_ready", recieve_ready, 1'b0);
    check_val("rst_pix_valid", pix_valid, 1'b0);
    check_val("rst_frame_count", frame_count, 16'd0);
    check_val("rst_frame_err", frame_err, 1'b0);
    check_val("rst_timeout_err", timeout_err, 1'b0);
    check_val("rst_pix_data", pix_data, 24'd0);
    repeat (5) tick();
    check_val("idle_no_request", recieve_ready, 1'b0);

    // Basic unpack order with pix_ready held high.
    enable = 1'b1;
    send_word(96'h112233_445566_778899_AABBCC, 1'b0, 1'b0);
    wait_drain();

    // Stall on the second pixel for five cycles.
    rdy_hold = 1'b0;
    send_word(96'h112233_445566_778899_AABBCC, 1'b0, 1'b0);
    n = 0;
    while (pix_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_val("stall_first_valid", pix_valid, 1'b1);
    rdy_hold = 1'b1;
    tick();
    rdy_hold = 1'b0;
    repeat (5) begin
      tick();
      check_val("stall_data", pix_data, 24'h445566);
      check_val("stall_valid", pix_valid, 1'b1);
      check_val("stall_no_req", recieve_ready, 1'b0);
    end
    rdy_hold = 1'b1;
    wait_drain();

    // Finish the first frame with two more words.
    send_word(rand_word(), 1'b0, 1'b0);
    send_word(rand_word(), 1'b0, 1'b0);
    wait_drain();
    check_val("frame1_count", frame_count, 16'd1);
    check_val("frame1_err", frame_err, 1'b0);

    // Early frame_end on the second word; level then stays high.
    send_word(rand_word(), 1'b0, 1'b0);
    send_word(rand_word(), 1'b1, 1'b0);
    send_word(rand_word(), 1'b1, 1'b0);
    wait_drain();
    check_val("early_fe_err", frame_err, m_ferr);
    check_val("early_fe_err_set", frame_err, 1'b1);
    check_val("early_fe_count", frame_count, 16'd2);
    send_word(rand_word(), 1'b0, 1'b0);
    send_word(rand_word(), 1'b0, 1'b0);
    send_word(rand_word(), 1'b0, 1'b0);
    wait_drain();
    check_val("frame3_count", frame_count, 16'd3);
    check_val("sticky_err", frame_err, 1'b1);

    // Enable dropped while the word is pending: word completes, then idle.
    send_word(rand_word(), 1'b0, 1'b1);
    wait_drain();
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (recieve_ready) seen = 1'b1;
    end
    check_val("disabled_no_request", seen, 1'b0);

    // Timeout with an unresponsive camera.
    do_reset();
    enable = 1'b1;
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_val("tmo_first_pulse", timeout_err, 1'b1);
    repeat (2) begin
      n    = 0;
      seen = 1'b0;
      do begin
        tick();
        n++;
        if (recieve_ready !== 1'b1) seen = 1'b1;
      end while (timeout_err !== 1'b1 && n < 40);
      check_val("tmo_period", n, TMO);
      check_val("tmo_rr_held", seen, 1'b0);
    end

    // Reset in the middle of unpacking drops the rest of the word.
    do_reset();
    enable   = 1'b1;
    rdy_hold = 1'b0;
    send_word(rand_word(), 1'b0, 1'b0);
    check_val("mid_unpack_valid", pix_valid, 1'b1);
    rst = 1'b1;
    tick();
    check_val("rst_mid_unpack_valid", pix_valid, 1'b0);
    rst      = 1'b0;
    enable   = 1'b0;
    model_reset();
    rdy_hold = 1'b1;
    seen     = 1'b0;
    repeat (10) begin
      tick();
      if (pix_valid) seen = 1'b1;
    end
    check_val("no_pixels_after_rst", seen, 1'b0);
    check_val("rst_mid_frame_count", frame_count, 16'd0);

    // Randomized traffic with random downstream back-pressure.
    do_reset();
    rdy_rand = 1'b1;
    enable   = 1'b1;
    for (int w = 0; w < 48; w++) begin
      lvl = ($urandom_range(0, 5) == 0) ? !frame_end : frame_end;
      send_word(rand_word(), lvl, 1'b0);
    end
    wait_drain();
    check_val("rand_frame_count", frame_count, 16'(m_fc));
    check_val("rand_frame_err", frame_err, m_ferr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
